// File: rtl/cpu_control_unit_if.sv
// Instruction-memory and ALU bus between the control unit (master) and the
// memory/ALU side (slave).
interface cpu_control_unit_if #(
  parameter int PC_W = 4
);
  logic [PC_W-1:0] imem_addr;
  logic [7:0]      imem_data;
  logic [3:0]      alu_a;
  logic [3:0]      alu_b;
  logic [2:0]      alu_op;
  logic [3:0]      alu_result;
  logic            alu_zero;

  modport master (
    output imem_addr, alu_a, alu_b, alu_op,
    input  imem_data, alu_result, alu_zero
  );

  modport slave (
    input  imem_addr, alu_a, alu_b, alu_op,
    output imem_data, alu_result, alu_zero
  );
endinterface

// File: rtl/cpu_control_unit.sv
// 3-cycle fetch/decode/execute sequencer in front of a 4-bit ALU.
// Define CTRL_SINGLE_STEP_EN to add the step input and a STEP_WAIT state after each EXECUTE.
module cpu_control_unit #(
  parameter int              PC_W     = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  cpu_control_unit_if.master bus,
  output logic [3:0]         acc,
  output logic               zero_flag,
  output logic               halted,
  output logic               busy
`ifdef CTRL_SINGLE_STEP_EN
  ,
  input  logic               step
`endif
);

  typedef struct packed {
    logic [2:0] op;
    logic       rsvd;
    logic [3:0] imm;
  } instr_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
`ifdef CTRL_SINGLE_STEP_EN
    ST_STEP_WAIT = 3'd5,
`endif
    ST_HALT    = 3'd4
  } state_e;

  localparam logic [2:0] OP_MOV  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_JMP  = 3'b011;
  localparam logic [2:0] OP_JZ   = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b111;

`ifdef CTRL_SINGLE_STEP_EN
  localparam state_e EXEC_NEXT = ST_STEP_WAIT;
`else
  localparam state_e EXEC_NEXT = ST_FETCH;
`endif

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  instr_t          ir_q, ir_d;
  logic [3:0]      acc_q, acc_d;
  logic            zf_q, zf_d;

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] imm_ext;

  assign pc_inc  = pc_q + PC_W'(1);
  assign imm_ext = PC_W'(ir_q.imm);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    zf_d    = zf_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        ir_d    = instr_t'(bus.imem_data);
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        state_d = EXEC_NEXT;
        case (ir_q.op)
          OP_MOV, OP_ADD, OP_SUB: begin
            acc_d = bus.alu_result;
            zf_d  = bus.alu_zero;
            pc_d  = pc_inc;
          end
          OP_JMP:  pc_d = imm_ext;
          // JZ tests the flag left by an earlier ALU op, never the current ALU output
          OP_JZ:   pc_d = zf_q ? imm_ext : pc_inc;
          OP_HALT: state_d = ST_HALT;
          default: pc_d = pc_inc;
        endcase
      end
`ifdef CTRL_SINGLE_STEP_EN
      ST_STEP_WAIT: if (step) state_d = ST_FETCH;
`endif
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      acc_q   <= '0;
      zf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      zf_q    <= zf_d;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.alu_a     = acc_q;
  assign bus.alu_b     = ir_q.imm;
  assign bus.alu_op    = ir_q.op;

  assign acc       = acc_q;
  assign zero_flag = zf_q;
  assign halted    = (state_q == ST_HALT);
`ifdef CTRL_SINGLE_STEP_EN
  assign busy      = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                     (state_q == ST_EXECUTE) || (state_q == ST_STEP_WAIT);
`else
  assign busy      = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                     (state_q == ST_EXECUTE);
`endif

endmodule

// File: tb/tb_cpu_control_unit.sv
// Scoreboard bench: an instruction-level program model queues the architectural
// state after every instruction; a monitor pops and compares at each retirement.
module tb_cpu_control_unit;
  localparam int PC_W = 4;
  localparam int NPC  = 1 << PC_W;
`ifdef CTRL_SINGLE_STEP_EN
  localparam int CYC = 4;
`else
  localparam int CYC = 3;
`endif

  localparam logic [2:0] I_MOV = 3'd0, I_ADD = 3'd1, I_SUB = 3'd2, I_JMP = 3'd3;
  localparam logic [2:0] I_JZ  = 3'd4, I_NOP = 3'd5, I_RSV = 3'd6, I_HLT = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] acc;
  logic       zero_flag, halted, busy;
`ifdef CTRL_SINGLE_STEP_EN
  logic       step = 1'b1;
`endif

  cpu_control_unit_if #(.PC_W(PC_W)) bus ();

  cpu_control_unit #(.PC_W(PC_W), .RESET_PC('0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus),
    .acc       (acc),
    .zero_flag (zero_flag),
    .halted    (halted),
    .busy      (busy)
`ifdef CTRL_SINGLE_STEP_EN
    ,
    .step      (step)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory and a plain 4-bit ALU.
  logic [7:0] mem [NPC];
  always @(posedge clk) bus.imem_data <= mem[bus.imem_addr];

  logic [3:0] alu_r;
  always_comb begin
    alu_r = bus.alu_a;
    case (bus.alu_op)
      I_MOV:   alu_r = bus.alu_b;
      I_ADD:   alu_r = bus.alu_a + bus.alu_b;
      I_SUB:   alu_r = bus.alu_a - bus.alu_b;
      default: alu_r = bus.alu_a;
    endcase
    bus.alu_result = alu_r;
    bus.alu_zero   = (alu_r == 4'd0);
  end

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [3:0]      acc;
    logic            zf;
    logic            hlt;
  } snap_t;

  snap_t exp_q[$];
  snap_t got_s, exp_s;
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b1;
  int    bcnt   = 0;

  // Retirement is visible CYC busy cycles after an instruction's fetch, or
  // when busy drops (HALT).
  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      bcnt = 0;
    end else begin
      if (bcnt == CYC || (bcnt > 0 && !busy)) begin
        got_s = '{bus.imem_addr, acc, zero_flag, halted};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL retire_extra: unexpected retirement pc=%0d acc=%0d zf=%0b hlt=%0b",
                   got_s.pc, got_s.acc, got_s.zf, got_s.hlt);
        end else begin
          exp_s = exp_q.pop_front();
          if (got_s !== exp_s) begin
            errors++;
            $display("FAIL retire: got pc=%0d acc=%0d zf=%0b hlt=%0b, expected pc=%0d acc=%0d zf=%0b hlt=%0b",
                     got_s.pc, got_s.acc, got_s.zf, got_s.hlt,
                     exp_s.pc, exp_s.acc, exp_s.zf, exp_s.hlt);
          end
        end
        bcnt = 0;
      end
      if (busy) bcnt++;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [7:0] ins(input logic [2:0] op, input logic [3:0] imm);
    return {op, 1'b0, imm};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < NPC; i++) mem[i] = ins(I_HLT, 4'd0);
  endtask

  // Instruction-level reference: runs the program from reset state.
  task automatic model(input int max_n, output int n, output bit h, output int fpc);
    int pc, a, z, op, imm;
    logic [7:0] w;
    snap_t e;
    pc = 0; a = 0; z = 0; n = 0; h = 1'b0;
    while (n < max_n && !h) begin
      w   = mem[pc];
      op  = int'(w[7:5]);
      imm = int'(w[3:0]);
      case (op)
        0: begin a = imm;              z = (a == 0); pc = (pc + 1) % NPC; end
        1: begin a = (a + imm) % 16;   z = (a == 0); pc = (pc + 1) % NPC; end
        2: begin a = (a - imm + 16) % 16; z = (a == 0); pc = (pc + 1) % NPC; end
        3: pc = imm;
        4: pc = (z != 0) ? imm : (pc + 1) % NPC;
        7: h = 1'b1;
        default: pc = (pc + 1) % NPC;
      endcase
      e.pc  = pc[PC_W-1:0];
      e.acc = a[3:0];
      e.zf  = z[0];
      e.hlt = h;
      exp_q.push_back(e);
      n++;
    end
    fpc = pc;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pc",   int'(bus.imem_addr), 0);
    chk("rst_state", int'({acc, zero_flag, halted, busy, bus.alu_op, bus.alu_b}), 0);
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic run_prog(input int max_n, output int hcyc);
    int n, fpc, c;
    bit h;
    do_reset();
    model(max_n, n, h, fpc);
    hcyc = -1;
    @(posedge clk); #1 start = 1'b1;
    c = 0;
    while (exp_q.size() != 0 && c < (max_n + 2) * CYC + 10) begin
      @(posedge clk); #1;
      c++;
      if (halted && hcyc < 0) hcyc = c - 1;
      start = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL retire_timeout: %0d retirements outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    if (h) begin
      start = 1'b1;
      repeat (4) @(negedge clk);
      chk("halt_hold_pc", int'(bus.imem_addr), fpc);
      chk("halt_hold_flags", int'({busy, halted}), 1);
      start = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hc, bad;

    // MOV 5, ADD 3, HALT
    clear_mem();
    mem[0] = ins(I_MOV, 4'd5); mem[1] = ins(I_ADD, 4'd3); mem[2] = ins(I_HLT, 4'd0);
    run_prog(8, hc);
    chk("halt_latency", hc, 9 + 2 * (CYC - 3));
    chk("prog1_acc", int'(acc), 8);

    // JZ taken and not taken
    clear_mem();
    mem[0] = ins(I_MOV, 4'd3); mem[1] = ins(I_SUB, 4'd3); mem[2] = ins(I_JZ, 4'd6);
    run_prog(8, hc);
    mem[0] = ins(I_MOV, 4'd4);
    run_prog(8, hc);

    // modulo-16 wrap to zero
    clear_mem();
    mem[0] = ins(I_MOV, 4'd1); mem[1] = ins(I_ADD, 4'd15);
    run_prog(8, hc);
    chk("wrap_acc_zf", int'({acc, zero_flag}), 1);

    // PC wrap: 0 jumps to 15, NOP at 15 advances to 0
    clear_mem();
    mem[0] = ins(I_JMP, 4'd15); mem[15] = ins(I_NOP, 4'd0);
    run_prog(4, hc);

    // reserved opcode and JMP preserve ACC/flag
    clear_mem();
    mem[0] = ins(I_MOV, 4'd0); mem[1] = ins(I_RSV, 4'd7); mem[2] = ins(I_JMP, 4'd9);
    run_prog(8, hc);
    mem[0] = ins(I_MOV, 4'd5);
    run_prog(8, hc);

    // reset lands while the instruction after MOV 7 is in DECODE
    clear_mem();
    mem[0] = ins(I_MOV, 4'd7);
    run_prog(1, hc);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_acc", int'(acc), 0);
    chk("midrst_pc", int'(bus.imem_addr), 0);
    chk("midrst_busy_halt", int'({busy, halted}), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy || bus.imem_addr != '0) bad++;
    end
    chk("no_fetch_without_start", bad, 0);

    // randomized programs
    for (int p = 0; p < 24; p++) begin
      for (int i = 0; i < NPC; i++) mem[i] = 8'($urandom_range(0, 255));
      run_prog(30, hc);
    end

`ifdef CTRL_SINGLE_STEP_EN
    mon_en = 1'b0;
    clear_mem();
    mem[0] = ins(I_MOV, 4'd1); mem[1] = ins(I_ADD, 4'd1); mem[2] = ins(I_ADD, 4'd1);
    step = 1'b0;
    do_reset();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(negedge clk);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!busy || bus.imem_addr != 4'd1 || acc != 4'd1) bad++;
    end
    chk("step_hold", bad, 0);
    @(posedge clk); #1 step = 1'b1;
    @(posedge clk); #1 step = 1'b0;
    repeat (12) @(negedge clk);
    chk("step_one_pc", int'(bus.imem_addr), 2);
    chk("step_one_acc", int'(acc), 2);
    chk("step_one_busy", int'(busy), 1);
    step = 1'b1;
    mon_en = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
